// File: rtl/lcd_message_writer_pkg.sv
// Shared definitions for the HD44780 message writer: command bytes, FSM
// encodings and small frame/command lookup helpers.
package lcd_message_writer_pkg;

   localparam logic [7:0] CMD_FUNC_SET = 8'h38;
   localparam logic [7:0] CMD_DISP_ON  = 8'h0C;
   localparam logic [7:0] CMD_CLEAR    = 8'h01;
   localparam logic [7:0] CMD_ENTRY    = 8'h06;
   localparam logic [7:0] CMD_LINE1    = 8'h80;
   localparam logic [7:0] CMD_LINE2    = 8'hC0;

   typedef enum logic [2:0] {
      ST_PWR_WAIT,
      ST_INIT,
      ST_IDLE,
      ST_LINE1_ADDR,
      ST_LINE1_CHARS,
      ST_LINE2_ADDR,
      ST_LINE2_CHARS
   } wr_state_t;

   typedef enum logic [1:0] {
      SND_IDLE,
      SND_SETUP,
      SND_STROBE,
      SND_WAIT
   } snd_state_t;

   // Power-up command list, issued in this order.
   function automatic logic [7:0] init_cmd(input logic [1:0] idx);
      logic [7:0] cmd;
      case (idx)
         2'd0:    cmd = CMD_FUNC_SET;
         2'd1:    cmd = CMD_DISP_ON;
         2'd2:    cmd = CMD_CLEAR;
         default: cmd = CMD_ENTRY;
      endcase
      return cmd;
   endfunction

   function automatic logic [7:0] frame_char(input logic [255:0] frame,
                                             input logic [4:0]   k);
      return frame[{k, 3'b000} +: 8];
   endfunction

endpackage

// File: rtl/lcd_message_writer_byte_sender.sv
// Sends one byte to the LCD: one setup cycle, T_PULSE cycles of E high, then a
// hold/wait of T_CMD (or T_CLEAR) cycles. All pin drivers are registers.
module lcd_message_writer_byte_sender
   import lcd_message_writer_pkg::*;
#(
   parameter int T_PULSE = 25,
   parameter int T_CMD   = 2500,
   parameter int T_CLEAR = 100000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       is_data,
   input  logic [7:0] tx_byte,
   input  logic       long_wait,
   output logic       ready,
   output logic [7:0] lcd_data,
   output logic       lcd_rs,
   output logic       lcd_e
);

   snd_state_t  state_reg;
   logic [31:0] cnt_reg;
   logic        long_reg;
   logic [7:0]  data_reg;
   logic        rs_reg;
   logic        e_reg;

   logic [31:0] wait_limit;
   logic        accept;

   assign wait_limit = long_reg ? 32'(T_CLEAR) : 32'(T_CMD);

   // ready marks the last wait cycle so the next byte's setup follows with no gap.
   assign ready  = (state_reg == SND_WAIT) && (cnt_reg == wait_limit - 32'd1);
   assign accept = (state_reg == SND_IDLE) || ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= SND_IDLE;
         cnt_reg   <= '0;
         long_reg  <= 1'b0;
         data_reg  <= 8'h00;
         rs_reg    <= 1'b0;
         e_reg     <= 1'b0;
      end else if (accept && start) begin
         state_reg <= SND_SETUP;
         cnt_reg   <= '0;
         long_reg  <= long_wait;
         data_reg  <= tx_byte;
         rs_reg    <= is_data;
         e_reg     <= 1'b0;
      end else begin
         case (state_reg)
            SND_SETUP: begin
               e_reg     <= 1'b1;
               cnt_reg   <= '0;
               state_reg <= SND_STROBE;
            end
            SND_STROBE: begin
               if (cnt_reg == 32'(T_PULSE - 1)) begin
                  e_reg     <= 1'b0;
                  cnt_reg   <= '0;
                  state_reg <= SND_WAIT;
               end else begin
                  cnt_reg <= cnt_reg + 32'd1;
               end
            end
            SND_WAIT: begin
               if (ready) begin
                  state_reg <= SND_IDLE;
               end else begin
                  cnt_reg <= cnt_reg + 32'd1;
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign lcd_data = data_reg;
   assign lcd_rs   = rs_reg;
   assign lcd_e    = e_reg;

endmodule

// File: rtl/lcd_message_writer.sv
// Writes a 32-character frame to a 16x2 HD44780 LCD (8-bit, write only) after
// running the power-up init sequence; refresh requests while busy are merged.
module lcd_message_writer
   import lcd_message_writer_pkg::*;
#(
   parameter int T_POWERUP = 750000,
   parameter int T_PULSE   = 25,
   parameter int T_CMD     = 2500,
   parameter int T_CLEAR   = 100000
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [255:0] message,
   input  logic         refresh,
   output logic [7:0]   lcd_data,
   output logic         lcd_rs,
   output logic         lcd_rw,
   output logic         lcd_e,
   output logic         busy,
   output logic         done
);

   wr_state_t    state_reg;
   logic [31:0]  pwr_cnt_reg;
   logic [1:0]   init_idx_reg;
   logic [4:0]   char_idx_reg;
   logic [255:0] shadow_reg;
   logic         pending_reg;
   logic         busy_reg;
   logic         done_reg;

   logic         snd_start;
   logic         snd_is_data;
   logic [7:0]   snd_byte;
   logic         snd_long;
   logic         snd_ready;
   logic         frame_start;
   logic         last_char;

   assign frame_start = (state_reg == ST_IDLE) && (refresh || pending_reg);
   assign last_char   = (char_idx_reg == 5'd15);

   // Next byte to hand to the sender; issued on the sender's last wait cycle.
   always_comb begin
      snd_start   = 1'b0;
      snd_is_data = 1'b0;
      snd_byte    = CMD_FUNC_SET;
      case (state_reg)
         ST_PWR_WAIT: begin
            snd_start = (pwr_cnt_reg == 32'(T_POWERUP - 1));
            snd_byte  = init_cmd(2'd0);
         end
         ST_INIT: begin
            snd_start = snd_ready && (init_idx_reg != 2'd3);
            snd_byte  = init_cmd(init_idx_reg + 2'd1);
         end
         ST_IDLE: begin
            snd_start = frame_start;
            snd_byte  = CMD_LINE1;
         end
         ST_LINE1_ADDR: begin
            snd_start   = snd_ready;
            snd_is_data = 1'b1;
            snd_byte    = frame_char(shadow_reg, 5'd0);
         end
         ST_LINE1_CHARS: begin
            snd_start = snd_ready;
            if (last_char) begin
               snd_byte = CMD_LINE2;
            end else begin
               snd_is_data = 1'b1;
               snd_byte    = frame_char(shadow_reg, {1'b0, 4'(char_idx_reg + 5'd1)});
            end
         end
         ST_LINE2_ADDR: begin
            snd_start   = snd_ready;
            snd_is_data = 1'b1;
            snd_byte    = frame_char(shadow_reg, 5'd16);
         end
         ST_LINE2_CHARS: begin
            snd_start   = snd_ready && !last_char;
            snd_is_data = 1'b1;
            snd_byte    = frame_char(shadow_reg, {1'b1, 4'(char_idx_reg + 5'd1)});
         end
         default: begin
         end
      endcase
      snd_long = !snd_is_data && (snd_byte == CMD_CLEAR);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg    <= ST_PWR_WAIT;
         pwr_cnt_reg  <= '0;
         init_idx_reg <= 2'd0;
         char_idx_reg <= 5'd0;
         shadow_reg   <= '0;
         pending_reg  <= 1'b0;
         busy_reg     <= 1'b1;
         done_reg     <= 1'b0;
      end else begin
         done_reg <= 1'b0;

         if (frame_start) begin
            pending_reg <= 1'b0;
         end else if (refresh && busy_reg) begin
            pending_reg <= 1'b1;
         end

         case (state_reg)
            ST_PWR_WAIT: begin
               pwr_cnt_reg <= pwr_cnt_reg + 32'd1;
               if (snd_start) begin
                  state_reg    <= ST_INIT;
                  init_idx_reg <= 2'd0;
               end
            end
            ST_INIT: begin
               if (snd_ready) begin
                  if (init_idx_reg == 2'd3) begin
                     state_reg <= ST_IDLE;
                     busy_reg  <= pending_reg || refresh;
                  end else begin
                     init_idx_reg <= init_idx_reg + 2'd1;
                  end
               end
            end
            ST_IDLE: begin
               if (frame_start) begin
                  state_reg    <= ST_LINE1_ADDR;
                  shadow_reg   <= message;
                  busy_reg     <= 1'b1;
                  char_idx_reg <= 5'd0;
               end
            end
            ST_LINE1_ADDR: begin
               if (snd_ready) begin
                  state_reg    <= ST_LINE1_CHARS;
                  char_idx_reg <= 5'd0;
               end
            end
            ST_LINE1_CHARS: begin
               if (snd_ready) begin
                  if (last_char) begin
                     state_reg    <= ST_LINE2_ADDR;
                     char_idx_reg <= 5'd0;
                  end else begin
                     char_idx_reg <= char_idx_reg + 5'd1;
                  end
               end
            end
            ST_LINE2_ADDR: begin
               if (snd_ready) begin
                  state_reg    <= ST_LINE2_CHARS;
                  char_idx_reg <= 5'd0;
               end
            end
            ST_LINE2_CHARS: begin
               if (snd_ready) begin
                  if (last_char) begin
                     state_reg <= ST_IDLE;
                     done_reg  <= 1'b1;
                     busy_reg  <= pending_reg || refresh;
                  end else begin
                     char_idx_reg <= char_idx_reg + 5'd1;
                  end
               end
            end
            default: begin
               state_reg <= ST_PWR_WAIT;
            end
         endcase
      end
   end

   lcd_message_writer_byte_sender #(
      .T_PULSE (T_PULSE),
      .T_CMD   (T_CMD),
      .T_CLEAR (T_CLEAR)
   ) u_sender (
      .clk       (clk),
      .rst       (rst),
      .start     (snd_start),
      .is_data   (snd_is_data),
      .tx_byte   (snd_byte),
      .long_wait (snd_long),
      .ready     (snd_ready),
      .lcd_data  (lcd_data),
      .lcd_rs    (lcd_rs),
      .lcd_e     (lcd_e)
   );

   assign lcd_rw = 1'b0;
   assign busy   = busy_reg;
   assign done   = done_reg;

endmodule

// File: tb/tb_lcd_message_writer.sv
// Directed bench for lcd_message_writer: expected LCD bytes are queued when
// stimulus is driven and compared as each E strobe rises.
module tb_lcd_message_writer;

   localparam int T_POWERUP = 20;
   localparam int T_PULSE   = 4;
   localparam int T_CMD     = 8;
   localparam int T_CLEAR   = 30;
   localparam int BYTE_T    = 1 + T_PULSE + T_CMD;
   localparam int FRAME_T   = 34 * BYTE_T;
   localparam int INIT_END  = T_POWERUP + 3 * BYTE_T + (1 + T_PULSE + T_CLEAR);

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         refresh = 1'b0;
   logic [255:0] message = '0;
   logic [7:0]   lcd_data;
   logic         lcd_rs;
   logic         lcd_rw;
   logic         lcd_e;
   logic         busy;
   logic         done;

   lcd_message_writer #(
      .T_POWERUP (T_POWERUP),
      .T_PULSE   (T_PULSE),
      .T_CMD     (T_CMD),
      .T_CLEAR   (T_CLEAR)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .message  (message),
      .refresh  (refresh),
      .lcd_data (lcd_data),
      .lcd_rs   (lcd_rs),
      .lcd_rw   (lcd_rw),
      .lcd_e    (lcd_e),
      .busy     (busy),
      .done     (done)
   );

   always #5 clk = ~clk;

   int         n_assert = 0;
   int         n_fail = 0;
   int         cyc = 0;
   int         rise_cnt = 0;
   int         last_rise_cyc = 0;
   int         last_fall_cyc = 0;
   int         done_cnt = 0;
   int         done_cyc = 0;
   logic [8:0] last_fall_val = 9'h1ff;
   logic [8:0] mon_exp;
   logic       prev_e = 1'b0;
   logic       done_busy = 1'b0;
   logic       busy_low_seen = 1'b0;
   logic [8:0] exp_q[$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_assert++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
      end
   endtask

   // Observer: one sample per cycle, 1 time unit after the active edge.
   always @(posedge clk) begin
      #1;
      cyc++;
      if (lcd_e && !prev_e) begin
         rise_cnt++;
         last_rise_cyc = cyc;
         check("rw_low", {31'd0, lcd_rw}, 32'd0);
         if (last_fall_val == 9'h001)
            check("clear_gap", cyc - 1 - last_fall_cyc, T_CLEAR);
         check("byte_expected", {31'd0, exp_q.size() > 0}, 32'd1);
         if (exp_q.size() > 0) begin
            mon_exp = exp_q.pop_front();
            check($sformatf("lcd_byte%0d", rise_cnt), {23'd0, lcd_rs, lcd_data}, {23'd0, mon_exp});
         end
      end
      if (!lcd_e && prev_e) begin
         last_fall_cyc = cyc;
         last_fall_val = {lcd_rs, lcd_data};
      end
      if (done) begin
         done_cnt++;
         done_cyc  = cyc;
         done_busy = busy;
      end
      if (!busy) busy_low_seen = 1'b1;
      prev_e = lcd_e;
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic pulse_refresh();
      refresh = 1'b1;
      @(negedge clk);
      refresh = 1'b0;
   endtask

   task automatic push_init();
      exp_q.push_back({1'b0, 8'h38});
      exp_q.push_back({1'b0, 8'h0C});
      exp_q.push_back({1'b0, 8'h01});
      exp_q.push_back({1'b0, 8'h06});
   endtask

   task automatic push_frame(input logic [255:0] m);
      exp_q.push_back({1'b0, 8'h80});
      for (int k = 0; k < 16; k++) exp_q.push_back({1'b1, m[8*k +: 8]});
      exp_q.push_back({1'b0, 8'hC0});
      for (int k = 16; k < 32; k++) exp_q.push_back({1'b1, m[8*k +: 8]});
   endtask

   function automatic logic [255:0] str_frame(input string s);
      logic [255:0] r;
      r = '0;
      for (int k = 0; k < 32; k++) r[8*k +: 8] = s[k];
      return r;
   endfunction

   task automatic wait_rises(input string tag, input int target, input int bound);
      int k;
      k = 0;
      while (rise_cnt < target && k < bound) begin
         @(negedge clk);
         k++;
      end
      check(tag, {31'd0, rise_cnt >= target}, 32'd1);
   endtask

   task automatic wait_done(input string tag, input int target, input int bound);
      int k;
      k = 0;
      while (done_cnt < target && k < bound) begin
         @(negedge clk);
         k++;
      end
      check(tag, {31'd0, done_cnt >= target}, 32'd1);
   endtask

   task automatic wait_busy_low(input string tag, input int bound);
      int k;
      k = 0;
      while (busy !== 1'b0 && k < bound) begin
         @(negedge clk);
         k++;
      end
      check(tag, {31'd0, busy}, 32'd0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [255:0] m1, mx, m3, m4;
      int base, start_cyc, d0, first_done;

      m1 = str_frame("NS:0012 SN:0034 EW:0056 WE:0078 ");
      mx = {32{8'h58}};
      for (int k = 0; k < 32; k++) m3[8*k +: 8] = 8'($urandom_range(0, 255));
      m3[7:0]     = 8'h00;
      m3[255:248] = 8'hFF;
      m4 = str_frame("Reset test: line1 second line ok");

      // Reset state
      rst = 1'b1;
      tick(3);
      check("rst_lcd_e", {31'd0, lcd_e}, 32'd0);
      check("rst_lcd_rs", {31'd0, lcd_rs}, 32'd0);
      check("rst_lcd_rw", {31'd0, lcd_rw}, 32'd0);
      check("rst_lcd_data", {24'd0, lcd_data}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd1);
      check("rst_done", {31'd0, done}, 32'd0);

      // Power-up and init
      rst = 1'b0;
      cyc = 0;
      push_init();
      base = rise_cnt;
      wait_rises("init_rise_seen", base + 1, 100);
      check("init_first_rise_cycle", last_rise_cyc, T_POWERUP + 1);
      wait_busy_low("init_busy_fall_seen", 200);
      check("init_busy_fall_cycle", cyc, INIT_END);
      check("init_byte_count", rise_cnt - base, 4);

      // Single frame, message swapped to all 'X' mid-frame
      tick(5);
      message = m1;
      push_frame(m1);
      d0 = done_cnt;
      start_cyc = cyc + 1;
      pulse_refresh();
      check("frame_busy_next_cycle", {31'd0, busy}, 32'd1);
      check("frame_setup_byte", {24'd0, lcd_data}, 32'h80);
      check("frame_setup_e_low", {31'd0, lcd_e}, 32'd0);
      tick(9);
      message = mx;
      wait_done("frame1_done_seen", d0 + 1, FRAME_T + 50);
      check("frame1_done_cycle", done_cyc, start_cyc + FRAME_T);
      check("frame1_busy_drop", {31'd0, busy}, 32'd0);
      tick(1);
      check("frame1_done_one_cycle", {31'd0, done}, 32'd0);
      tick(20);
      check("frame1_done_count", done_cnt, d0 + 1);
      check("frame1_queue_empty", exp_q.size(), 0);

      // Two requests mid-frame merge into one follow-on frame
      push_frame(mx);
      d0 = done_cnt;
      start_cyc = cyc + 1;
      pulse_refresh();
      busy_low_seen = 1'b0;
      tick(40);
      pulse_refresh();
      tick(30);
      message = m3;
      push_frame(m3);
      tick(30);
      pulse_refresh();
      wait_done("pend_done1_seen", d0 + 1, FRAME_T);
      check("pend_done1_cycle", done_cyc, start_cyc + FRAME_T);
      check("pend_busy_at_done", {31'd0, done_busy}, 32'd1);
      first_done = done_cyc;
      tick(10);
      check("pend_busy_held", {31'd0, busy_low_seen}, 32'd0);
      wait_done("pend_done2_seen", d0 + 2, FRAME_T + 50);
      check("pend_done2_cycle", done_cyc, first_done + 1 + FRAME_T);
      tick(FRAME_T + 20);
      check("pend_total_dones", done_cnt, d0 + 2);
      check("pend_queue_empty", exp_q.size(), 0);

      // Reset during character 20 with a request pending
      message = m1;
      push_frame(m1);
      base = rise_cnt;
      pulse_refresh();
      tick(20);
      pulse_refresh();
      wait_rises("mid_char20_seen", base + 23, 23 * BYTE_T + 20);
      rst = 1'b1;
      exp_q.delete();
      tick(1);
      check("midrst_lcd_e", {31'd0, lcd_e}, 32'd0);
      check("midrst_lcd_data", {24'd0, lcd_data}, 32'd0);
      check("midrst_busy", {31'd0, busy}, 32'd1);
      check("midrst_done", {31'd0, done}, 32'd0);
      tick(1);
      rst = 1'b0;
      cyc = 0;
      push_init();
      base = rise_cnt;
      d0 = done_cnt;
      wait_rises("reinit_rise_seen", base + 1, 100);
      check("reinit_first_rise_cycle", last_rise_cyc, T_POWERUP + 1);
      wait_busy_low("reinit_busy_fall_seen", 200);
      check("reinit_busy_fall_cycle", cyc, INIT_END);
      tick(150);
      check("reinit_no_frame", rise_cnt - base, 4);
      check("reinit_no_done", done_cnt, d0);
      check("reinit_queue_empty", exp_q.size(), 0);

      // Request during init starts a frame right after init
      rst = 1'b1;
      tick(2);
      rst = 1'b0;
      cyc = 0;
      push_init();
      message = m4;
      push_frame(m4);
      d0 = done_cnt;
      busy_low_seen = 1'b0;
      tick(40);
      pulse_refresh();
      tick(150);
      check("initpend_busy_held", {31'd0, busy_low_seen}, 32'd0);
      wait_done("initpend_done_seen", d0 + 1, FRAME_T + 50);
      check("initpend_done_cycle", done_cyc, INIT_END + 1 + FRAME_T);
      tick(5);
      check("initpend_queue_empty", exp_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
